// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared definitions for the two-port Ram arbiter:
//   - arb_state_t : FSM state encoding (IDLE, ACCESS, DONE)
//   - AW_DEF/DW_DEF : default address/data widths of the 16x8 Ram
//   - PORT_A/PORT_B : requester ids used for grants and the RR pointer
package ram_arb_pkg;

  localparam int AW_DEF = 4;
  localparam int DW_DEF = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } arb_state_t;

endpackage

// File: rtl/ram_arb_pick.sv
// ram_arb_pick
// Combinational winner selection between the two requesters.
// Build option: RAM_ARB_RR_EN selects round-robin on conflict; otherwise
// port A always wins a conflict and last_served is ignored.
// Ports:
//   a_req, b_req  in  pending requests from port A / port B
//   last_served   in  id of the port granted most recently
//   grant_valid   out at least one request is pending
//   grant_id      out id of the winning port (PORT_A/PORT_B)
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_served,
  output logic grant_valid,
  output logic grant_id
);

  // A lone request is granted directly; only a conflict consults the policy.
  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = PORT_A;
`ifdef RAM_ARB_RR_EN
    if (a_req && b_req) begin
      grant_id = (last_served == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      grant_id = PORT_B;
    end
`else
    if (!a_req && b_req) begin
      grant_id = PORT_B;
    end
`endif
  end

`ifndef RAM_ARB_RR_EN
  // Fixed priority has no use for the pointer.
  logic w_unusedLastServed;
  assign w_unusedLastServed = last_served;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Serialises read/write requests from two requesters (A = CPU datapath,
// B = loader/DMA) onto one single-port Ram (sync write, comb read).
// Each access takes IDLE -> ACCESS -> DONE, acking the winner in DONE.
// Build option: RAM_ARB_RR_EN enables round-robin arbitration on conflict
// (default: fixed A priority, no pointer register).
// Ports:
//   clk, reset (sync, active-low)
//   a_req/a_we/a_addr/a_wdata in, a_ack/a_rdata out   port A
//   b_req/b_we/b_addr/b_wdata in, b_ack/b_rdata out   port B
//   MemWrite/MemRead/Address/WriteData out, MemData_out in   Ram side
//   busy out   high whenever the FSM is not IDLE
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_ack,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          MemWrite,
  output logic          MemRead,
  output logic [AW-1:0] Address,
  output logic [DW-1:0] WriteData,
  input  logic [DW-1:0] MemData_out,
  output logic          busy
);

  arb_state_t    r_state;
  arb_state_t    w_nextState;
  logic          r_winner;
  logic          r_memWrite;
  logic          r_memRead;
  logic [AW-1:0] r_address;
  logic [DW-1:0] r_writeData;
  logic          r_aAck;
  logic          r_bAck;
  logic [DW-1:0] r_aRdata;
  logic [DW-1:0] r_bRdata;
  logic          w_lastServed;
  logic          w_grantValid;
  logic          w_grantId;

`ifdef RAM_ARB_RR_EN
  logic r_lastServed;
  assign w_lastServed = r_lastServed;
`else
  assign w_lastServed = PORT_B;
`endif

  ram_arb_pick u_pick (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_served (w_lastServed),
    .grant_valid (w_grantValid),
    .grant_id    (w_grantId)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state: arbitrate only from IDLE; DONE always returns to IDLE so
  // requesters get one edge to drop or replace their request.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_grantValid) w_nextState = ACCESS;
      ACCESS:  w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Command, ack and read-data registers. Reset aborts any access in
  // flight without an ack and clears both rdata registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_winner    <= PORT_A;
      r_memWrite  <= 1'b0;
      r_memRead   <= 1'b0;
      r_address   <= '0;
      r_writeData <= '0;
      r_aAck      <= 1'b0;
      r_bAck      <= 1'b0;
      r_aRdata    <= '0;
      r_bRdata    <= '0;
`ifdef RAM_ARB_RR_EN
      r_lastServed <= PORT_B;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          r_aAck <= 1'b0;
          r_bAck <= 1'b0;
          if (w_grantValid) begin
            r_winner <= w_grantId;
            if (w_grantId == PORT_B) begin
              r_memWrite  <= b_we;
              r_memRead   <= ~b_we;
              r_address   <= b_addr;
              r_writeData <= b_wdata;
            end else begin
              r_memWrite  <= a_we;
              r_memRead   <= ~a_we;
              r_address   <= a_addr;
              r_writeData <= a_wdata;
            end
`ifdef RAM_ARB_RR_EN
            r_lastServed <= w_grantId;
`endif
          end
        end
        ACCESS: begin
          r_memWrite <= 1'b0;
          r_memRead  <= 1'b0;
          if (r_memRead) begin
            if (r_winner == PORT_A) begin
              r_aRdata <= MemData_out;
            end else begin
              r_bRdata <= MemData_out;
            end
          end
          r_aAck <= (r_winner == PORT_A);
          r_bAck <= (r_winner == PORT_B);
        end
        DONE: begin
          r_aAck <= 1'b0;
          r_bAck <= 1'b0;
        end
        default: begin
          r_aAck <= 1'b0;
          r_bAck <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe is gated by reset so the Ram never commits while reset is low.
  assign MemWrite  = r_memWrite & reset;
  assign MemRead   = r_memRead;
  assign Address   = r_address;
  assign WriteData = r_writeData;
  assign a_ack     = r_aAck;
  assign b_ack     = r_bAck;
  assign a_rdata   = r_aRdata;
  assign b_rdata   = r_bRdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural 16x8 Ram attached.
// Expected values are hand-computed from the access sequence below.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic       MemWrite, MemRead;
  logic [3:0] Address;
  logic [7:0] WriteData;
  logic [7:0] MemData_out;
  logic       busy;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] ramMem [16];

  // 10 ns clock.
  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ack       (a_ack),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_ack       (b_ack),
    .b_rdata     (b_rdata),
    .MemWrite    (MemWrite),
    .MemRead     (MemRead),
    .Address     (Address),
    .WriteData   (WriteData),
    .MemData_out (MemData_out),
    .busy        (busy)
  );

  // Behavioural Ram: synchronous write, combinational read, powers up zero.
  initial begin
    for (int i = 0; i < 16; i++) ramMem[i] = 8'h00;
  end

  always @(posedge clk) begin
    if (MemWrite) ramMem[Address] <= WriteData;
  end

  assign MemData_out = ramMem[Address];

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One uncontested access from an idle arbiter, checking every phase.
  task automatic applyStimulus(input logic port, input logic we,
                               input logic [3:0] addr, input logic [7:0] wdata);
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
    tick();
    checkOutput("access_busy", 32'(busy), 32'd1);
    checkOutput("access_memwrite", 32'(MemWrite), 32'(we));
    checkOutput("access_memread", 32'(MemRead), 32'(!we));
    checkOutput("access_address", 32'(Address), 32'(addr));
    if (we) checkOutput("access_wdata", 32'(WriteData), 32'(wdata));
    checkOutput("access_no_ack", 32'({a_ack, b_ack}), 32'd0);
    tick();
    checkOutput("done_ack", 32'({a_ack, b_ack}), (port == 1'b0) ? 32'd2 : 32'd1);
    checkOutput("done_memwrite", 32'(MemWrite), 32'd0);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_ack", 32'({a_ack, b_ack}), 32'd0);
  endtask

  // Both ports read in the same IDLE cycle; aFirst selects expected winner.
  task automatic conflictRead(input logic aFirst);
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'h1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'h2;
    tick();
    checkOutput("conf1_address", 32'(Address), aFirst ? 32'h1 : 32'h2);
    tick();
    checkOutput("conf1_ack", 32'({a_ack, b_ack}), aFirst ? 32'd2 : 32'd1);
    if (aFirst) begin
      checkOutput("conf1_rdata", 32'(a_rdata), 32'hAA);
      a_req = 1'b0;
    end else begin
      checkOutput("conf1_rdata", 32'(b_rdata), 32'hF0);
      b_req = 1'b0;
    end
    tick();
    checkOutput("conf_gap_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("conf2_address", 32'(Address), aFirst ? 32'h2 : 32'h1);
    tick();
    checkOutput("conf2_ack", 32'({a_ack, b_ack}), aFirst ? 32'd1 : 32'd2);
    if (aFirst) checkOutput("conf2_rdata", 32'(b_rdata), 32'hF0);
    else        checkOutput("conf2_rdata", 32'(a_rdata), 32'hAA);
    a_req = 1'b0;
    b_req = 1'b0;
    tick();
    checkOutput("conf_end_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic secondConflictAFirst;
`ifdef RAM_ARB_RR_EN
    secondConflictAFirst = 1'b0;
`else
    secondConflictAFirst = 1'b1;
`endif

    // Reset held with both ports requesting writes.
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'h5; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'h6; b_wdata = 8'h22;
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_acks", 32'({a_ack, b_ack}), 32'd0);
      checkOutput("rst_mem_cmd", 32'({MemWrite, MemRead}), 32'd0);
      checkOutput("rst_addr_data", 32'({Address, WriteData}), 32'd0);
      checkOutput("rst_rdata", 32'({a_rdata, b_rdata}), 32'd0);
    end
    a_req = 1'b0; b_req = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("rst_no_write", 32'({ramMem[5], ramMem[6]}), 32'd0);

    $display("[TB] A write/read");
    applyStimulus(1'b0, 1'b1, 4'h1, 8'hAA);
    applyStimulus(1'b0, 1'b0, 4'h1, 8'h00);
    checkOutput("a_read_1", 32'(a_rdata), 32'hAA);

    $display("[TB] B write, A read");
    applyStimulus(1'b1, 1'b1, 4'h2, 8'hF0);
    checkOutput("b_rdata_after_write", 32'(b_rdata), 32'h00);
    applyStimulus(1'b0, 1'b0, 4'h2, 8'h00);
    checkOutput("a_read_2", 32'(a_rdata), 32'hF0);
    checkOutput("b_rdata_unchanged", 32'(b_rdata), 32'h00);

    $display("[TB] Reset during B write ACCESS");
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'h3; b_wdata = 8'h55;
    tick();
    checkOutput("abort_access_memwrite", 32'(MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("abort_gated_memwrite", 32'(MemWrite), 32'd0);
    tick();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_no_ack", 32'({a_ack, b_ack}), 32'd0);
    checkOutput("abort_rdata_cleared", 32'(a_rdata), 32'h00);
    b_req = 1'b0;
    reset = 1'b1;
    tick();
    checkOutput("abort_still_no_ack", 32'({a_ack, b_ack, busy}), 32'd0);

    $display("[TB] Unwritten address and aborted write");
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00);
    checkOutput("a_read_0", 32'(a_rdata), 32'h00);
    applyStimulus(1'b0, 1'b0, 4'h2, 8'h00);
    checkOutput("a_read_2_again", 32'(a_rdata), 32'hF0);
    applyStimulus(1'b0, 1'b0, 4'h3, 8'h00);
    checkOutput("a_read_3_unwritten", 32'(a_rdata), 32'h00);

    $display("[TB] Conflicts");
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    conflictRead(1'b1);
    applyStimulus(1'b0, 1'b0, 4'h1, 8'h00);
    conflictRead(secondConflictAFirst);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Hard stop in case the sequence above is ever held up.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
